// File: rtl/clk_div_pkg.sv
// Shared constants and capture-time clamping for the programmable clock-enable divider.
package clk_div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 18;
  localparam int DEF_HIGH  = 9;

  typedef struct packed {
    logic [31:0] div;
    logic [31:0] high;
  } div_cfg_t;

  // A period shorter than 2 cannot hold both a high and a low slot; high time never exceeds the period.
  function automatic div_cfg_t clamp_cfg(input logic [31:0] div, input logic [31:0] high);
    div_cfg_t c;
    c.div  = (div < 32'd2) ? 32'd2 : div;
    c.high = (high > c.div) ? c.div : high;
    return c;
  endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Shadow divisor/high-time registers, pending flag, and the period-boundary apply/ack logic.
module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic             boundary,
  output logic [WIDTH-1:0] div_act,
  output logic [WIDTH-1:0] high_act,
  output logic [WIDTH-1:0] high_nxt,
  output logic             ack
);

  logic [WIDTH-1:0] div_sh_q, div_sh_d;
  logic [WIDTH-1:0] high_sh_q, high_sh_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] high_act_q, high_act_d;
  logic             pending_q, pending_d;
  logic             ack_q, ack_d;
  logic             apply;
  div_cfg_t         cfg;

  // A load landing on the same edge as an apply stays pending for the following boundary.
  always_comb begin
    cfg        = clamp_cfg(32'(div_in), 32'(high_in));
    apply      = boundary && pending_q;
    div_sh_d   = div_sh_q;
    high_sh_d  = high_sh_q;
    div_act_d  = div_act_q;
    high_act_d = high_act_q;
    pending_d  = pending_q && !apply;
    ack_d      = apply;
    if (apply) begin
      div_act_d  = div_sh_q;
      high_act_d = high_sh_q;
    end
    if (load) begin
      div_sh_d  = WIDTH'(cfg.div);
      high_sh_d = WIDTH'(cfg.high);
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    div_sh_q  <= div_sh_d;
    high_sh_q <= high_sh_d;
    if (rst) begin
      div_act_q  <= WIDTH'(DEFAULT_DIV);
      high_act_q <= WIDTH'(DEFAULT_HIGH);
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      div_act_q  <= div_act_d;
      high_act_q <= high_act_d;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
    end
  end

  assign div_act  = div_act_q;
  assign high_act = high_act_q;
  assign high_nxt = high_act_d;
  assign ack      = ack_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock-enable divider: slot counter, registered divided level and edge strobes.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic             clkI,
  input  logic             rstI,
  input  logic             enI,
  input  logic [WIDTH-1:0] divI,
  input  logic [WIDTH-1:0] highI,
  input  logic             loadI,
  output logic             loadAckO,
  output logic             clkO,
  output logic             riseO,
  output logic             fallO,
  output logic [WIDTH-1:0] cntO
);

  logic             run_q, run_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             wrap;
  logic             boundary;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] high_act;
  logic [WIDTH-1:0] high_nxt;

  clk_div_shadow #(
    .WIDTH        (WIDTH),
    .DEFAULT_DIV  (DEFAULT_DIV),
    .DEFAULT_HIGH (DEFAULT_HIGH)
  ) u_shadow (
    .clk      (clkI),
    .rst      (rstI),
    .load     (loadI),
    .div_in   (divI),
    .high_in  (highI),
    .boundary (boundary),
    .div_act  (div_act),
    .high_act (high_act),
    .high_nxt (high_nxt),
    .ack      (loadAckO)
  );

  // The output level is derived from next-state values so clkO, cntO and the strobes share one edge.
  always_comb begin
    wrap     = (cnt_q == div_act - WIDTH'(1));
    boundary = enI && (!run_q || wrap);
    run_d    = run_q;
    cnt_d    = cnt_q;
    if (enI) begin
      run_d = 1'b1;
      cnt_d = boundary ? '0 : cnt_q + WIDTH'(1);
    end
    clk_d  = run_d && (cnt_d < high_nxt);
    rise_d = clk_d && !clk_q;
    fall_d = !clk_d && clk_q;
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign clkO  = clk_q;
  assign riseO = rise_q;
  assign fallO = fall_q;
  assign cntO  = cnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: behavioural period model checked every cycle, directed scenarios, random traffic.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div = 8'd0;
  logic [7:0] high = 8'd0;
  logic       ack_o, clk_o, rise_o, fall_o;
  logic [7:0] cnt_o;

  int total = 0;
  int bad = 0;

  clk_div_prog dut (
    .clkI     (clk),
    .rstI     (rst),
    .enI      (en),
    .divI     (div),
    .highI    (high),
    .loadI    (load),
    .loadAckO (ack_o),
    .clkO     (clk_o),
    .riseO    (rise_o),
    .fallO    (fall_o),
    .cntO     (cnt_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: slot index advances modulo the active period; new settings take effect when the slot returns to 0.
  bit mdl_ok = 1'b0;
  int m_cnt, m_per, m_hi, m_pdiv, m_phigh;
  bit m_run, m_pend, m_clk, m_rise, m_fall, m_ack, m_prev, m_bnd;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_cnt = 0; m_per = 18; m_hi = 9; m_pend = 0;
      m_clk = 0; m_rise = 0; m_fall = 0; m_ack = 0;
      mdl_ok = 1'b1;
    end else if (mdl_ok) begin
      m_prev = m_clk;
      m_ack = 0;
      if (en) begin
        if (!m_run) begin
          m_run = 1; m_cnt = 0; m_bnd = 1;
        end else begin
          m_cnt = (m_cnt + 1) % m_per;
          m_bnd = (m_cnt == 0);
        end
        if (m_bnd && m_pend) begin
          m_per = m_pdiv; m_hi = m_phigh; m_pend = 0; m_ack = 1;
        end
      end
      if (load) begin
        m_pdiv  = (int'(div) < 2) ? 2 : int'(div);
        m_phigh = (int'(high) > m_pdiv) ? m_pdiv : int'(high);
        m_pend  = 1;
      end
      m_clk  = m_run && (m_cnt < m_hi);
      m_rise = m_clk && !m_prev;
      m_fall = !m_clk && m_prev;
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("mdl_clkO", int'(clk_o), int'(m_clk));
      chk("mdl_cntO", int'(cnt_o), m_cnt);
      chk("mdl_riseO", int'(rise_o), int'(m_rise));
      chk("mdl_fallO", int'(fall_o), int'(m_fall));
      chk("mdl_loadAckO", int'(ack_o), int'(m_ack));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ack(input string nm, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ack_o && n < 100);
    if (!ack_o) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic window(input int n, output int highs, output int rises, output int falls,
                        output int acks, output int maxc);
    highs = 0; rises = 0; falls = 0; acks = 0; maxc = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      highs += int'(clk_o);
      rises += int'(rise_o);
      falls += int'(fall_o);
      acks  += int'(ack_o);
      if (int'(cnt_o) > maxc) maxc = int'(cnt_o);
    end
  endtask

  initial begin
    int n, hs, rs, fs, as, mc;
    cyc(); cyc();
    chk("rst_clkO", int'(clk_o), 0);
    chk("rst_cntO", int'(cnt_o), 0);
    chk("rst_riseO", int'(rise_o), 0);
    chk("rst_ackO", int'(ack_o), 0);
    rst = 0;
    cyc();
    chk("idle_clkO", int'(clk_o), 0);

    // Defaults: 18-cycle period, 9 high.
    en = 1;
    cyc();
    chk("start_cnt", int'(cnt_o), 0);
    chk("start_clk", int'(clk_o), 1);
    chk("start_rise", int'(rise_o), 1);
    window(35, hs, rs, fs, as, mc);
    chk("def_highs", hs, 17);
    chk("def_rises", rs, 1);
    chk("def_falls", fs, 2);
    chk("def_maxcnt", mc, 17);
    chk("def_endcnt", int'(cnt_o), 17);
    repeat (6) cyc();
    chk("at_cnt5", int'(cnt_o), 5);

    // Load 14/7 mid-period.
    load = 1; div = 8'd14; high = 8'd7;
    cyc();
    load = 0;
    wait_ack("ld14", n);
    chk("ld14_latency", n, 12);
    chk("ld14_ack_cnt", int'(cnt_o), 0);
    chk("ld14_ack_clk", int'(clk_o), 1);
    window(28, hs, rs, fs, as, mc);
    chk("p14_highs", hs, 14);
    chk("p14_rises", rs, 2);
    chk("p14_falls", fs, 2);
    chk("p14_maxcnt", mc, 13);

    // Two loads before the wrap: last one wins.
    load = 1; div = 8'd20; high = 8'd10;
    cyc();
    load = 0;
    cyc();
    load = 1; div = 8'd16; high = 8'd4;
    cyc();
    load = 0;
    wait_ack("ld16", n);
    chk("ld16_latency", n, 11);
    window(32, hs, rs, fs, as, mc);
    chk("p16_highs", hs, 8);
    chk("p16_rises", rs, 2);
    chk("p16_acks", as, 0);
    chk("p16_maxcnt", mc, 15);

    // Enable low for 5 cycles at cnt 12.
    repeat (12) cyc();
    chk("at_cnt12", int'(cnt_o), 12);
    en = 0;
    window(5, hs, rs, fs, as, mc);
    chk("hold_cnt", int'(cnt_o), 12);
    chk("hold_strobes", rs + fs + as, 0);
    en = 1;
    cyc();
    chk("resume_cnt", int'(cnt_o), 13);

    // Clamp: 0/0 becomes period 2 with no high time.
    load = 1; div = 8'd0; high = 8'd0;
    cyc();
    load = 0;
    wait_ack("ld0", n);
    chk("ld0_latency", n, 2);
    window(10, hs, rs, fs, as, mc);
    chk("p2_highs", hs, 0);
    chk("p2_strobes", rs + fs, 0);
    chk("p2_maxcnt", mc, 1);

    // high == div: constantly high after a single rise.
    load = 1; div = 8'd6; high = 8'd6;
    cyc();
    load = 0;
    wait_ack("ld6", n);
    chk("ld6_rise", int'(rise_o), 1);
    chk("ld6_clk", int'(clk_o), 1);
    window(20, hs, rs, fs, as, mc);
    chk("p6_highs", hs, 20);
    chk("p6_strobes", rs + fs, 0);

    // Reset mid-period with a simultaneous load that must be discarded.
    rst = 1; load = 1; div = 8'd10; high = 8'd3;
    cyc();
    chk("mrst_clk", int'(clk_o), 0);
    chk("mrst_cnt", int'(cnt_o), 0);
    chk("mrst_fall", int'(fall_o), 0);
    rst = 0; load = 0;
    cyc();
    chk("mrst_start_clk", int'(clk_o), 1);
    chk("mrst_start_ack", int'(ack_o), 0);
    window(17, hs, rs, fs, as, mc);
    chk("mrst_highs", hs, 8);
    chk("mrst_falls", fs, 1);
    chk("mrst_acks", as, 0);
    chk("mrst_maxcnt", mc, 17);

    // Random traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 15) == 0);
      div  = 8'($urandom_range(0, 25));
      high = 8'($urandom_range(0, 30));
      cyc();
    end
    rst = 0; en = 0; load = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
